// File: rtl/cia_pkg.sv
// rtl/cia_pkg.sv - shared constants, FSM encoding and counter-width helper for the serial subtractor
package cia_pkg;

    localparam int BLK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter indexing n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cia_inc_block4.sv
// rtl/cia_inc_block4.sv - combinational 4-bit carry-increment block (ripple sum, then +cin increment)
module cia_inc_block4
    import cia_pkg::*;
(
    input  logic [BLK_W-1:0] x_i,
    input  logic [BLK_W-1:0] y_i,
    input  logic             cin_i,
    output logic [BLK_W-1:0] s_o,
    output logic             cout_o
);

    logic [BLK_W:0]   rc;
    logic [BLK_W:0]   ic;
    logic [BLK_W-1:0] r;

    // Sum assuming cin=0, then a half-adder chain adds cin; at most one chain can carry out.
    always_comb begin
        rc    = '0;
        ic    = '0;
        r     = '0;
        s_o   = '0;
        ic[0] = cin_i;
        for (int i = 0; i < BLK_W; i++) begin
            r[i]    = x_i[i] ^ y_i[i] ^ rc[i];
            rc[i+1] = (x_i[i] & y_i[i]) | (rc[i] & (x_i[i] ^ y_i[i]));
        end
        for (int i = 0; i < BLK_W; i++) begin
            s_o[i]  = r[i] ^ ic[i];
            ic[i+1] = r[i] & ic[i];
        end
        cout_o = rc[BLK_W] | ic[BLK_W];
    end

endmodule

// File: rtl/cia_serial_subtractor.sv
// rtl/cia_serial_subtractor.sv - multi-cycle a - b - bin using one shared 4-bit carry-increment block
// Optional signed-overflow output enabled by defining CIA_SUB_OVF_EN.
module cia_serial_subtractor
    import cia_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef CIA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK = WIDTH / BLK_W;
    localparam int CW   = clog2(NBLK);
    localparam logic [CW-1:0] LAST = CW'(NBLK - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef CIA_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [BLK_W-1:0] blk_x, blk_y, blk_s;
    logic             blk_cout;

    assign blk_x = a_q[cnt_q*BLK_W +: BLK_W];
    assign blk_y = nb_q[cnt_q*BLK_W +: BLK_W];

    cia_inc_block4 u_blk (
        .x_i    (blk_x),
        .y_i    (blk_y),
        .cin_i  (carry_q),
        .s_o    (blk_s),
        .cout_o (blk_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
`ifdef CIA_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    diff_d  = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                diff_d[cnt_q*BLK_W +: BLK_W] = blk_s;
                carry_d = blk_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    bout_d  = ~blk_cout;
`ifdef CIA_SUB_OVF_EN
                    // Subtrahend MSB is recovered from its stored complement.
                    ovf_d = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ blk_s[BLK_W-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef CIA_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
`ifdef CIA_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef CIA_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cia_serial_subtractor.sv
// tb/tb_cia_serial_subtractor.sv - directed and random self-checking bench for cia_serial_subtractor (WIDTH=16)
module tb_cia_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
`ifdef CIA_SUB_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    cia_serial_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef CIA_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    // Latency = rising edges from the accept edge through the edge that raises out_valid.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_op,
                          input logic tbin, input logic [15:0] exp_diff, input logic exp_bout,
                          input int stall, input bit keep_valid, input bit chk_lat);
        int w;
        int lat;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_op;
        bin      = tbin;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        a   = ~ta;
        b   = ~tb_op;
        bin = ~tbin;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (chk_lat) chk({tag, "_latency"}, 32'(lat), 32'd5);
        chk({tag, "_diff"}, {16'd0, diff}, {16'd0, exp_diff});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_bout});
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            @(negedge clk);
            chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "_stall_diff"}, {16'd0, diff}, {16'd0, exp_diff});
            chk({tag, "_stall_bout"}, {31'd0, bout}, {31'd0, exp_bout});
        end
        if (!keep_valid) in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_idle_ovalid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [16:0] g;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {16'd0, diff}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
`ifdef CIA_SUB_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 0, 1'b0, 1'b1);
        run_op("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 0, 1'b0, 1'b1);
        run_op("t3a", 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
        run_op("t3b", 16'h0007, 16'h0007, 1'b1, 16'hFFFF, 1'b1, 0, 1'b0, 1'b0);
        run_op("t4a", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 0, 1'b0, 1'b0);
`ifdef CIA_SUB_OVF_EN
        chk("t4a_ovf", {31'd0, ovf}, 32'd1);
`endif
        run_op("t4b", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 0, 1'b0, 1'b0);
`ifdef CIA_SUB_OVF_EN
        chk("t4b_ovf", {31'd0, ovf}, 32'd1);
`endif
        run_op("t5", 16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 3, 1'b0, 1'b0);

        // Abort mid-RUN: rst is sampled on the edge ending the second RUN cycle.
        in_valid = 1'b1;
        a        = 16'h5555;
        b        = 16'h1111;
        bin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_in_run", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t6_diff", {16'd0, diff}, 32'd0);
        chk("t6_bout", {31'd0, bout}, 32'd0);
        run_op("t6_fresh", 16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            if (n % 5 == 0) rb = ra;
            g = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            run_op("rnd", ra, rb, rbin, g[15:0], g[16], int'($urandom_range(0, 2)),
                   (n >= 1500), 1'b1);
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
